gpio_ddr_write_sequencer: RTL and testbench

Bus-side controller for the GPIO DDR (direction) register bank at word addresses 0x440–0x445 (byte 0x1100–0x1114). After reset it loads the default direction words, then forwards host register writes, one at a time. Each write is a fixed setup/strobe/hold sequence that the decoder's two-stage write synchroniser and one-cycle address/data registers capture safely. It sits between the HPS bus slave and the GPIO address decoder, and is the sole driver of that decoder's write_reg, busaddress and busdata_in.

---
 rtl/gpio_ddr_write_sequencer_pkg.sv | 22 ++
 rtl/gpio_ddr_write_sequencer_if.sv | 32 +++
 rtl/gpio_bus_strobe_gen.sv | 75 +++++++
 rtl/gpio_ddr_write_sequencer.sv | 172 +++++++++++++++++
 tb/tb_gpio_ddr_write_sequencer.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/gpio_ddr_write_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gpio_ctrl_pkg
// Brief   : Shared state encoding and DDR bank constants for the GPIO write path
// Revision: 1.0
// ============================================================================
package gpio_ctrl_pkg;

  typedef enum logic [2:0] {
    INIT_SEL = 3'd0,
    SETUP    = 3'd1,
    STROBE   = 3'd2,
    HOLD     = 3'd3,
    IDLE     = 3'd4
  } gpio_state_t;

  localparam logic [11:0] DDR_BASE_WORD  = 12'h440;
  localparam int          DDR_WORD_WIDTH = 24;
  localparam int          CNT_WIDTH      = 8;

endpackage
`default_nettype wire

// File: rtl/gpio_ddr_write_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : gpio_ddr_write_sequencer_if
// Brief   : Host request and decoder write bus of the DDR write sequencer
// Revision: 1.0
// ============================================================================
interface gpio_ddr_write_sequencer_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int BUS_WIDTH  = 32
);
  logic                  init_start;
  logic                  host_write;
  logic [ADDR_WIDTH-3:0] host_addr;
  logic [BUS_WIDTH-1:0]  host_data;
  logic                  host_ready;
  logic                  overrun;
  logic                  init_done;
  logic                  write_reg;
  logic [ADDR_WIDTH-3:0] busaddress;
  logic [BUS_WIDTH-1:0]  busdata_out;

  modport master (
    output init_start, host_write, host_addr, host_data,
    input  host_ready, overrun, init_done, write_reg, busaddress, busdata_out
  );

  modport slave (
    input  init_start, host_write, host_addr, host_data,
    output host_ready, overrun, init_done, write_reg, busaddress, busdata_out
  );
endinterface
`default_nettype wire

// File: rtl/gpio_bus_strobe_gen.sv
`default_nettype none
// ============================================================================
// Module  : gpio_bus_strobe_gen
// Brief   : Setup/strobe/hold timer producing a registered write strobe
// Revision: 1.0
// ============================================================================
module gpio_bus_strobe_gen
  import gpio_ctrl_pkg::*;
(
  input  wire                 CLOCK,
  input  wire                 reset_reg,
  input  wire                 start,
  input  wire [CNT_WIDTH-1:0] setup_cycles,
  input  wire [CNT_WIDTH-1:0] strobe_cycles,
  input  wire [CNT_WIDTH-1:0] hold_cycles,
  output logic                write_reg,
  output logic                done
);

  gpio_state_t          r_phase;
  gpio_state_t          w_phase_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 r_write_reg;

  always_ff @(posedge CLOCK or posedge reset_reg) begin
    if (reset_reg) begin
      r_phase     <= IDLE;
      r_cnt       <= '0;
      r_write_reg <= 1'b0;
    end else begin
      r_phase     <= w_phase_nxt;
      r_cnt       <= w_cnt_nxt;
      r_write_reg <= (w_phase_nxt == STROBE);
    end
  end

  // done marks the final HOLD cycle, so the caller moves on in step with the timer
  always_comb begin
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_cnt + 1'b1;
    done        = 1'b0;
    unique case (r_phase)
      SETUP: begin
        if (r_cnt == setup_cycles - 1'b1) begin
          w_phase_nxt = STROBE;
          w_cnt_nxt   = '0;
        end
      end
      STROBE: begin
        if (r_cnt == strobe_cycles - 1'b1) begin
          w_phase_nxt = HOLD;
          w_cnt_nxt   = '0;
        end
      end
      HOLD: begin
        if (r_cnt == hold_cycles - 1'b1) begin
          w_phase_nxt = IDLE;
          w_cnt_nxt   = '0;
          done        = 1'b1;
        end
      end
      default: begin
        w_cnt_nxt = '0;
        if (start) begin
          w_phase_nxt = SETUP;
        end
      end
    endcase
  end

  assign write_reg = r_write_reg;

endmodule
`default_nettype wire

// File: rtl/gpio_ddr_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : gpio_ddr_write_sequencer
// Brief   : Loads default DDR words after reset, then forwards host writes
// Revision: 1.0
// ============================================================================
module gpio_ddr_write_sequencer
  import gpio_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH    = 14,
  parameter int BUS_WIDTH     = 32,
  parameter int NUM_IO_REG    = 6,
  parameter int STROBE_CYCLES = 4,
  parameter int SETUP_CYCLES  = 2,
  parameter int HOLD_CYCLES   = 2
) (
  input  wire                                   CLOCK,
  input  wire                                   reset_reg,
  input  wire [NUM_IO_REG*DDR_WORD_WIDTH-1:0]   def_ddr,
  gpio_ddr_write_sequencer_if.slave             bus
);

  localparam int WA    = ADDR_WIDTH - 2;
  localparam int IDX_W = (NUM_IO_REG > 1) ? $clog2(NUM_IO_REG) : 1;
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_IO_REG - 1);

  // Top-level SETUP stands for the whole in-flight transaction; the timer splits it further
  gpio_state_t          r_state;
  gpio_state_t          w_state_nxt;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic                 r_initing;
  logic                 w_initing_nxt;
  logic                 r_init_req;
  logic                 w_init_req_nxt;
  logic                 r_init_done;
  logic                 w_init_done_nxt;
  logic                 w_load_init;
  logic                 w_take_pend;
  logic                 w_start;
  logic                 w_done;
  logic                 w_write_reg;

  logic                 r_pend_valid;
  logic [WA-1:0]        r_pend_addr;
  logic [BUS_WIDTH-1:0] r_pend_data;
  logic                 r_overrun;
  logic [WA-1:0]        r_busaddress;
  logic [BUS_WIDTH-1:0] r_busdata;

  logic [DDR_WORD_WIDTH-1:0] w_init_word;
  logic [WA-1:0]             w_init_addr;
  logic [BUS_WIDTH-1:0]      w_init_data;

  assign w_init_word = def_ddr[r_idx*DDR_WORD_WIDTH +: DDR_WORD_WIDTH];
  assign w_init_addr = WA'(DDR_BASE_WORD) + WA'(r_idx);
  assign w_init_data = {{(BUS_WIDTH-DDR_WORD_WIDTH){1'b0}}, w_init_word};

  gpio_bus_strobe_gen u_strobe (
    .CLOCK         (CLOCK),
    .reset_reg     (reset_reg),
    .start         (w_start),
    .setup_cycles  (CNT_WIDTH'(SETUP_CYCLES)),
    .strobe_cycles (CNT_WIDTH'(STROBE_CYCLES)),
    .hold_cycles   (CNT_WIDTH'(HOLD_CYCLES)),
    .write_reg     (w_write_reg),
    .done          (w_done)
  );

  always_ff @(posedge CLOCK or posedge reset_reg) begin
    if (reset_reg) begin
      r_state     <= INIT_SEL;
      r_idx       <= '0;
      r_initing   <= 1'b1;
      r_init_req  <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_initing   <= w_initing_nxt;
      r_init_req  <= w_init_req_nxt;
      r_init_done <= w_init_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_initing_nxt   = r_initing;
    w_init_done_nxt = r_init_done;
    w_init_req_nxt  = r_init_req | bus.init_start;
    w_load_init     = 1'b0;
    w_take_pend     = 1'b0;
    w_start         = 1'b0;
    unique case (r_state)
      INIT_SEL: begin
        w_load_init = 1'b1;
        w_start     = 1'b1;
        w_state_nxt = SETUP;
      end
      SETUP: begin
        if (w_done) begin
          if (r_initing && (r_idx != c_last_idx)) begin
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = INIT_SEL;
          end else begin
            if (r_initing) begin
              w_init_done_nxt = 1'b1;
            end
            w_initing_nxt = 1'b0;
            w_state_nxt   = IDLE;
          end
        end
      end
      default: begin
        if (w_init_req_nxt) begin
          w_init_req_nxt  = 1'b0;
          w_init_done_nxt = 1'b0;
          w_initing_nxt   = 1'b1;
          w_idx_nxt       = '0;
          w_state_nxt     = INIT_SEL;
        end else if (r_pend_valid) begin
          w_take_pend = 1'b1;
          w_start     = 1'b1;
          w_state_nxt = SETUP;
        end
      end
    endcase
  end

  // A write arriving as the slot drains takes the freed slot rather than overrunning
  always_ff @(posedge CLOCK or posedge reset_reg) begin
    if (reset_reg) begin
      r_pend_valid <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_data  <= '0;
      r_overrun    <= 1'b0;
    end else if (bus.host_write) begin
      if (!r_pend_valid || w_take_pend) begin
        r_pend_valid <= 1'b1;
        r_pend_addr  <= bus.host_addr;
        r_pend_data  <= bus.host_data;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (w_take_pend) begin
      r_pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLOCK or posedge reset_reg) begin
    if (reset_reg) begin
      r_busaddress <= '0;
      r_busdata    <= '0;
    end else if (w_load_init) begin
      r_busaddress <= w_init_addr;
      r_busdata    <= w_init_data;
    end else if (w_take_pend) begin
      r_busaddress <= r_pend_addr;
      r_busdata    <= r_pend_data;
    end
  end

  assign bus.write_reg   = w_write_reg;
  assign bus.busaddress  = r_busaddress;
  assign bus.busdata_out = r_busdata;
  assign bus.init_done   = r_init_done;
  assign bus.overrun     = r_overrun;
  assign bus.host_ready  = ~r_pend_valid;

endmodule
`default_nettype wire

// File: tb/tb_gpio_ddr_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_gpio_ddr_write_sequencer
// Brief   : Directed self-checking bench for the GPIO DDR write sequencer
// Revision: 1.0
// ============================================================================
module tb_gpio_ddr_write_sequencer;

  logic         CLOCK;
  logic         reset_reg;
  logic [143:0] def_ddr;
  int           checks;
  int           failures;

  gpio_ddr_write_sequencer_if #(.ADDR_WIDTH(14), .BUS_WIDTH(32)) bus_if ();

  gpio_ddr_write_sequencer #(
    .ADDR_WIDTH    (14),
    .BUS_WIDTH     (32),
    .NUM_IO_REG    (6),
    .STROBE_CYCLES (4),
    .SETUP_CYCLES  (2),
    .HOLD_CYCLES   (2)
  ) dut (
    .CLOCK     (CLOCK),
    .reset_reg (reset_reg),
    .def_ddr   (def_ddr),
    .bus       (bus_if.slave)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // Ticks index from..to of an 8-clock transaction; strobe is high on indices 2..5
  task automatic xfer(input logic [11:0] a, input logic [31:0] d, input int from, input int to);
    for (int i = from; i <= to; i++) begin
      tick();
      chk($sformatf("wr_%0h_%0d", a, i), 32'(bus_if.write_reg), 32'((i >= 2) && (i <= 5)));
      chk($sformatf("addr_%0h_%0d", a, i), 32'(bus_if.busaddress), 32'(a));
      chk($sformatf("data_%0h_%0d", a, i), bus_if.busdata_out, d);
    end
  endtask

  task automatic init_load();
    for (int i = 0; i < 6; i++) begin
      xfer(12'h440 + 12'(i), 32'h100 + 32'(i), 0, 7);
      tick();
      chk($sformatf("init_done_%0d", i), 32'(bus_if.init_done), 32'(i == 5));
      chk($sformatf("init_gap_wr_%0d", i), 32'(bus_if.write_reg), 32'h0);
    end
  endtask

  task automatic host_wr(input logic [11:0] a, input logic [31:0] d);
    bus_if.host_write = 1'b1;
    bus_if.host_addr  = a;
    bus_if.host_data  = d;
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_wr"},    32'(bus_if.write_reg),  32'h0);
    chk({tag, "_addr"},  32'(bus_if.busaddress), 32'h0);
    chk({tag, "_data"},  bus_if.busdata_out,     32'h0);
    chk({tag, "_done"},  32'(bus_if.init_done),  32'h0);
    chk({tag, "_ovr"},   32'(bus_if.overrun),    32'h0);
    chk({tag, "_ready"}, 32'(bus_if.host_ready), 32'h1);
  endtask

  initial begin
    checks            = 0;
    failures          = 0;
    reset_reg         = 1'b1;
    bus_if.init_start = 1'b0;
    bus_if.host_write = 1'b0;
    bus_if.host_addr  = '0;
    bus_if.host_data  = '0;
    for (int i = 0; i < 6; i++) def_ddr[i*24 +: 24] = 24'h000100 + 24'(i);

    // Reset and default load
    repeat (2) @(posedge CLOCK);
    #1;
    reset_vals("rst");
    reset_reg = 1'b0;
    init_load();

    // Single host write from IDLE
    host_wr(12'h441, 32'h3FF);
    tick();
    bus_if.host_write = 1'b0;
    chk("t2_ready_e0", 32'(bus_if.host_ready), 32'h0);
    xfer(12'h441, 32'h3FF, 0, 0);
    chk("t2_ready_e1", 32'(bus_if.host_ready), 32'h1);
    xfer(12'h441, 32'h3FF, 1, 7);
    tick();

    // Write arriving on the cycle the pending slot drains
    host_wr(12'h442, 32'hA);
    tick();
    bus_if.host_write = 1'b0;
    xfer(12'h442, 32'hA, 0, 1);
    host_wr(12'h443, 32'hB);
    xfer(12'h442, 32'hA, 2, 2);
    bus_if.host_write = 1'b0;
    chk("t6_ready_b", 32'(bus_if.host_ready), 32'h0);
    xfer(12'h442, 32'hA, 3, 7);
    tick();
    chk("t6_idle_wr", 32'(bus_if.write_reg), 32'h0);
    host_wr(12'h444, 32'hC);
    xfer(12'h443, 32'hB, 0, 0);
    bus_if.host_write = 1'b0;
    chk("t6_ready_c", 32'(bus_if.host_ready), 32'h0);
    chk("t6_ovr_c", 32'(bus_if.overrun), 32'h0);
    xfer(12'h443, 32'hB, 1, 7);
    tick();
    xfer(12'h444, 32'hC, 0, 7);
    tick();
    chk("t6_ready_end", 32'(bus_if.host_ready), 32'h1);
    chk("t6_ovr_end", 32'(bus_if.overrun), 32'h0);

    // Three consecutive writes: run, hold, drop
    host_wr(12'h101, 32'h11);
    tick();
    host_wr(12'h102, 32'h22);
    xfer(12'h101, 32'h11, 0, 0);
    chk("t3_ovr_b", 32'(bus_if.overrun), 32'h0);
    chk("t3_ready_b", 32'(bus_if.host_ready), 32'h0);
    host_wr(12'h103, 32'h33);
    xfer(12'h101, 32'h11, 1, 1);
    bus_if.host_write = 1'b0;
    chk("t3_ovr_c", 32'(bus_if.overrun), 32'h1);
    xfer(12'h101, 32'h11, 2, 7);
    tick();
    chk("t3_gap_wr", 32'(bus_if.write_reg), 32'h0);
    chk("t3_gap_addr", 32'(bus_if.busaddress), 32'h101);
    xfer(12'h102, 32'h22, 0, 7);
    tick();
    chk("t3_ready_end", 32'(bus_if.host_ready), 32'h1);
    chk("t3_ovr_sticky", 32'(bus_if.overrun), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t3_nodrop_wr_%0d", i), 32'(bus_if.write_reg), 32'h0);
      chk($sformatf("t3_nodrop_addr_%0d", i), 32'(bus_if.busaddress), 32'h102);
    end

    // init_start during a host transaction with a write pending
    host_wr(12'h201, 32'h44);
    tick();
    bus_if.host_write = 1'b0;
    xfer(12'h201, 32'h44, 0, 0);
    host_wr(12'h202, 32'h55);
    xfer(12'h201, 32'h44, 1, 1);
    bus_if.host_write = 1'b0;
    bus_if.init_start = 1'b1;
    xfer(12'h201, 32'h44, 2, 2);
    bus_if.init_start = 1'b0;
    chk("t4_done_mid", 32'(bus_if.init_done), 32'h1);
    xfer(12'h201, 32'h44, 3, 7);
    tick();
    chk("t4_done_idle", 32'(bus_if.init_done), 32'h1);
    chk("t4_ready_idle", 32'(bus_if.host_ready), 32'h0);
    tick();
    chk("t4_done_cleared", 32'(bus_if.init_done), 32'h0);
    init_load();
    chk("t4_pend_waiting", 32'(bus_if.host_ready), 32'h0);
    xfer(12'h202, 32'h55, 0, 7);
    tick();
    chk("t4_ready_end", 32'(bus_if.host_ready), 32'h1);

    // Reset asserted during STROBE
    host_wr(12'h123, 32'h66);
    tick();
    bus_if.host_write = 1'b0;
    xfer(12'h123, 32'h66, 0, 3);
    reset_reg = 1'b1;
    #1;
    reset_vals("t5_async");
    tick();
    tick();
    reset_vals("t5_held");
    reset_reg = 1'b0;
    init_load();
    chk("t5_ovr_end", 32'(bus_if.overrun), 32'h0);
    chk("t5_ready_end", 32'(bus_if.host_ready), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
